spi_slv16: RTL and testbench

- Synthesizable 16-bit SPI responder: the slave end of the link driven by SPI_mstr16.
- Lets the FPGA act as an SPI peripheral for board bring-up, and serves as a loopback target for SPI_mstr16 in place of a behavioural slave model.
- Samples the master's SS_n/SCLK/MOSI in the clk domain, shifts one word in, returns a preloaded word on MISO, and flags word completion to local logic.

---
 rtl/spi_slv16.sv | 115 +++++++++++
 tb/tb_spi_slv16.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spi_slv16.sv
// spi_slv16: SPI slave, MSB-first WIDTH-bit frames sampled in the clk domain; returns a preloaded word on MISO.
// Define SPI_SLV_MISO_TRI_EN to float MISO while deselected or in reset.
module spi_slv16 #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             wrt,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             frm_err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] ss_q, sclk_q, mosi_q;
  logic ss_d, sclk_d, ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [WIDTH-1:0] shadow, shift, shift_n, rx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic miso_q, miso_n, extra, extra_n, rdy_n, err_n;
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign ss_fall = ss_d & ~ss_s;
  assign ss_rise = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n = cnt;
    rx_n = rx_data;
    rdy_n = 1'b0;
    err_n = 1'b0;
    miso_n = miso_q;
    extra_n = extra;
    if (state == IDLE) begin
      if (ss_fall) begin
        shift_n = wrt ? tx_data : shadow;
        miso_n = wrt ? tx_data[WIDTH-1] : shadow[WIDTH-1];
        cnt_n = '0;
        extra_n = 1'b0;
        state_n = SHIFT;
      end
    end else if (state == SHIFT) begin
      if (ss_rise) begin
        err_n = 1'b1;
        state_n = IDLE;
      end else if (sclk_rise) begin
        shift_n = {shift[WIDTH-2:0], mosi_s};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          rx_n = shift_n;
          rdy_n = 1'b1;
          state_n = DONE;
        end
      end else if (sclk_fall && cnt != '0) begin
        // the leading fall (count 0) must not disturb the MSB already on MISO
        miso_n = shift[WIDTH-1];
      end
    end else begin
      if (ss_rise) begin
        err_n = extra;
        state_n = IDLE;
      end else if (sclk_rise) begin
        extra_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_q <= '1;
      sclk_q <= '1;
      mosi_q <= '0;
      ss_d <= 1'b1;
      sclk_d <= 1'b1;
      state <= IDLE;
      shadow <= '0;
      shift <= '0;
      cnt <= '0;
      rx_data <= '0;
      rdy <= 1'b0;
      frm_err <= 1'b0;
      miso_q <= 1'b0;
      extra <= 1'b0;
    end else begin
      ss_q <= {ss_q[SYNC_STAGES-2:0], SS_n};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      ss_d <= ss_s;
      sclk_d <= sclk_s;
      state <= state_n;
      shadow <= wrt ? tx_data : shadow;
      shift <= shift_n;
      cnt <= cnt_n;
      rx_data <= rx_n;
      rdy <= rdy_n;
      frm_err <= err_n;
      miso_q <= miso_n;
      extra <= extra_n;
    end
  end
`ifdef SPI_SLV_MISO_TRI_EN
  assign MISO = (!rst_n || ss_s) ? 1'bz : miso_q;
`else
  assign MISO = miso_q;
`endif
endmodule

// File: tb/tb_spi_slv16.sv
// tb_spi_slv16: directed SPI master stimulus against spi_slv16 with immediate-assertion checks.
module tb_spi_slv16;
  logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0, wrt = 1'b0;
  logic [15:0] tx_data = '0;
  wire MISO;
  logic [15:0] rx_data;
  logic rdy, frm_err;
  int n_cmp = 0, n_err = 0;
  int rdy_cnt = 0, err_cnt = 0, both = 0, r0 = 0, e0 = 0;
  logic [15:0] rcv = '0;
  spi_slv16 dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .wrt(wrt), .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rdy) rdy_cnt++;
    if (frm_err) err_cnt++;
    if (rdy && frm_err) both++;
  end
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_wrt(input logic [15:0] v);
    tx_data = v;
    wrt = 1'b1;
    clks(1);
    wrt = 1'b0;
  endtask
  task automatic mark();
    r0 = rdy_cnt;
    e0 = err_cnt;
  endtask
  task automatic ss_low();
    SS_n = 1'b0;
    clks(5);
  endtask
  task automatic ss_high();
    SS_n = 1'b1;
    clks(8);
  endtask
  task automatic bits(input logic [15:0] w, input int from, input int to);
    for (int i = from; i < to; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? w[15-i] : 1'b0;
      clks(5);
      if (i < 16) rcv[15-i] = MISO;
      SCLK = 1'b1;
      clks(5);
    end
  endtask
  task automatic frame(input logic [15:0] w);
    ss_low();
    bits(w, 0, 16);
    ss_high();
  endtask
  initial begin
    clks(3);
    rst_n = 1'b1;
    clks(2);
    chk("reset_rx", rx_data, 16'h0000);
    chk("reset_rdy", {15'b0, rdy}, 16'h0000);
    chk("reset_err", {15'b0, frm_err}, 16'h0000);
`ifdef SPI_SLV_MISO_TRI_EN
    chk("reset_miso", {15'b0, MISO}, {15'b0, 1'bz});
`else
    chk("reset_miso", {15'b0, MISO}, 16'h0000);
`endif
    do_wrt(16'h0C05);
    mark();
    frame(16'h2800);
    chk("f1_miso", rcv, 16'h0C05);
    chk("f1_rx", rx_data, 16'h2800);
    chk("f1_rdy", 16'(rdy_cnt - r0), 16'd1);
    chk("f1_err", 16'(err_cnt - e0), 16'd0);
    do_wrt(16'h0BF4);
    mark();
    frame(16'h1357);
    chk("f2_miso", rcv, 16'h0BF4);
    chk("f2_rx", rx_data, 16'h1357);
    chk("f2_rdy", 16'(rdy_cnt - r0), 16'd1);
    do_wrt(16'h1234);
    ss_low();
    bits(16'hABCD, 0, 4);
    do_wrt(16'hA5A5);
    bits(16'hABCD, 4, 16);
    ss_high();
    chk("mid_wrt_miso", rcv, 16'h1234);
    chk("mid_wrt_rx", rx_data, 16'hABCD);
    frame(16'h5A5A);
    chk("next_miso", rcv, 16'hA5A5);
    chk("next_rx", rx_data, 16'h5A5A);
    mark();
    ss_low();
    bits(16'hFFFF, 0, 9);
    ss_high();
    chk("short_err", 16'(err_cnt - e0), 16'd1);
    chk("short_rdy", 16'(rdy_cnt - r0), 16'd0);
    chk("short_rx", rx_data, 16'h5A5A);
    mark();
    frame(16'h0F0F);
    chk("recover_miso", rcv, 16'hA5A5);
    chk("recover_rx", rx_data, 16'h0F0F);
    chk("recover_err", 16'(err_cnt - e0), 16'd0);
    mark();
    ss_low();
    bits(16'hFFFF, 0, 5);
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    SS_n = 1'b1;
    clks(8);
    chk("midrst_rx", rx_data, 16'h0000);
    chk("midrst_rdy", 16'(rdy_cnt - r0), 16'd0);
    chk("midrst_err", 16'(err_cnt - e0), 16'd0);
    frame(16'hFFFF);
    chk("postrst_miso", rcv, 16'h0000);
    chk("postrst_rx", rx_data, 16'hFFFF);
    do_wrt(16'h8421);
    mark();
    ss_low();
    bits(16'hC3C3, 0, 17);
    chk("long_rdy", 16'(rdy_cnt - r0), 16'd1);
    chk("long_err_pre", 16'(err_cnt - e0), 16'd0);
    ss_high();
    chk("long_err", 16'(err_cnt - e0), 16'd1);
    chk("long_rx", rx_data, 16'hC3C3);
    chk("long_miso", rcv, 16'h8421);
`ifdef SPI_SLV_MISO_TRI_EN
    chk("idle_miso_z", {15'b0, MISO}, {15'b0, 1'bz});
`endif
    chk("never_both", 16'(both), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
